// File: rtl/sad.sv
// 8x8 sum-of-absolute-differences engine: abs-diff row stage, adder tree, block accumulator.
// Define SAD_PIPE_EN to register pair sums inside the adder tree (adds one cycle of latency).
module sad #(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned ROW_PIX = 8,
    parameter int unsigned ROWS    = 8,
    parameter int unsigned SAD_W   = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       crt_keep,
    input  logic [PIX_W*ROW_PIX-1:0]   pre_frame,
    input  logic [PIX_W*ROW_PIX-1:0]   crt_frame,
    output logic [SAD_W-1:0]           sad_data
);

    localparam int unsigned CNT_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned RSUM_W = PIX_W + $clog2(ROW_PIX);
    localparam logic [CNT_W-1:0] LastRow = CNT_W'(ROWS - 1);

    // Stage S1: per-pixel absolute differences
    logic [PIX_W-1:0] ad_d [ROW_PIX];
    logic [PIX_W-1:0] d_q  [ROW_PIX];
    logic             v1_q, last1_q;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;

    always_comb begin
        for (int i = 0; i < ROW_PIX; i++) begin
            if (pre_frame[i*PIX_W +: PIX_W] >= crt_frame[i*PIX_W +: PIX_W]) begin
                ad_d[i] = pre_frame[i*PIX_W +: PIX_W] - crt_frame[i*PIX_W +: PIX_W];
            end else begin
                ad_d[i] = crt_frame[i*PIX_W +: PIX_W] - pre_frame[i*PIX_W +: PIX_W];
            end
        end
    end

    assign row_cnt_d = (row_cnt_q == LastRow) ? '0 : row_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROW_PIX; i++) begin
                d_q[i] <= '0;
            end
            v1_q      <= 1'b0;
            last1_q   <= 1'b0;
            row_cnt_q <= '0;
        end else begin
            v1_q <= crt_keep;
            if (crt_keep) begin
                d_q       <= ad_d;
                last1_q   <= (row_cnt_q == LastRow);
                row_cnt_q <= row_cnt_d;
            end
        end
    end

    // Stage S2: adder tree producing the row sum
    logic [RSUM_W-1:0] rowsum_d, rowsum_q;
    logic              s2_v, s2_last;
    logic              v2_q, last2_q;

`ifdef SAD_PIPE_EN
    logic [PIX_W:0] pair_q [ROW_PIX/2];
    logic           vp_q, lastp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < ROW_PIX / 2; j++) begin
                pair_q[j] <= '0;
            end
            vp_q    <= 1'b0;
            lastp_q <= 1'b0;
        end else begin
            vp_q    <= v1_q;
            lastp_q <= last1_q;
            if (v1_q) begin
                for (int j = 0; j < ROW_PIX / 2; j++) begin
                    pair_q[j] <= {1'b0, d_q[2*j]} + {1'b0, d_q[2*j+1]};
                end
            end
        end
    end

    always_comb begin
        rowsum_d = '0;
        for (int j = 0; j < ROW_PIX / 2; j++) begin
            rowsum_d = rowsum_d + RSUM_W'(pair_q[j]);
        end
    end

    assign s2_v    = vp_q;
    assign s2_last = lastp_q;
`else
    always_comb begin
        rowsum_d = '0;
        for (int i = 0; i < ROW_PIX; i++) begin
            rowsum_d = rowsum_d + RSUM_W'(d_q[i]);
        end
    end

    assign s2_v    = v1_q;
    assign s2_last = last1_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rowsum_q <= '0;
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
        end else begin
            v2_q    <= s2_v;
            last2_q <= s2_last;
            if (s2_v) begin
                rowsum_q <= rowsum_d;
            end
        end
    end

    // Stage S3: block accumulator; the final row bypasses acc straight into the result
    logic [SAD_W-1:0] acc_q, acc_d;
    logic [SAD_W-1:0] sad_q, sad_d;

    always_comb begin
        acc_d = acc_q;
        sad_d = sad_q;
        if (v2_q) begin
            if (last2_q) begin
                sad_d = acc_q + SAD_W'(rowsum_q);
                acc_d = '0;
            end else begin
                acc_d = acc_q + SAD_W'(rowsum_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            sad_q <= '0;
        end else begin
            acc_q <= acc_d;
            sad_q <= sad_d;
        end
    end

    assign sad_data = sad_q;

endmodule

// File: tb/tb_sad.sv
// Self-checking bench for sad: directed block vectors, corner sequences and a random run
// checked cycle-by-cycle against a row/block-level reference model.
module tb_sad;

`ifdef SAD_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        crt_keep;
    logic [63:0] pre_frame;
    logic [63:0] crt_frame;
    logic [13:0] sad_data;

    sad dut (
        .clk       (clk),
        .rst       (rst),
        .crt_keep  (crt_keep),
        .pre_frame (pre_frame),
        .crt_frame (crt_frame),
        .sad_data  (sad_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: rows collected per block; a finished block's SAD becomes visible LAT edges later.
    int unsigned m_acc  = 0;
    int          m_rows = 0;
    int unsigned m_sad  = 0;
    int          edge_n = 0;
    int          due_q[$];
    int unsigned val_q[$];

    function automatic int unsigned row_sad(input logic [63:0] p, input logic [63:0] c);
        int unsigned s = 0;
        for (int i = 0; i < 8; i++) begin
            int a = int'(p[8*i +: 8]);
            int b = int'(c[8*i +: 8]);
            s += (a > b) ? a - b : b - a;
        end
        return s;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic k, input logic [63:0] p, input logic [63:0] c);
        crt_keep  = k;
        pre_frame = p;
        crt_frame = c;
        @(posedge clk);
        edge_n++;
        while (due_q.size() > 0 && due_q[0] == edge_n) begin
            m_sad = val_q.pop_front();
            void'(due_q.pop_front());
        end
        if (k) begin
            m_acc += row_sad(p, c);
            m_rows++;
            if (m_rows == 8) begin
                due_q.push_back(edge_n + LAT);
                val_q.push_back(m_acc);
                m_acc  = 0;
                m_rows = 0;
            end
        end
        #1;
        check("sad_cycle", sad_data, m_sad);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 64'h0, 64'h0);
    endtask

    task automatic do_reset();
        crt_keep = 1'b0;
        rst      = 1'b0;
        #2;
        m_acc  = 0;
        m_rows = 0;
        m_sad  = 0;
        due_q.delete();
        val_q.delete();
        check("reset_async", sad_data, 0);
        @(posedge clk);
        edge_n++;
        #1;
        check("reset_held", sad_data, 0);
        rst = 1'b1;
    endtask

    typedef struct {
        string       name;
        logic [63:0] pre;
        logic [63:0] crt;
        bit          gaps;
        int unsigned exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [63:0] p, c;
        vecs[0] = '{"all_ff",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 16320};
        vecs[1] = '{"equal",   64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0, 0};
        vecs[2] = '{"all_10",  64'h1010_1010_1010_1010, 64'h0, 1'b0, 1024};
        vecs[3] = '{"rev_gap", 64'h0505_0505_0505_0505, 64'h0A0A_0A0A_0A0A_0A0A, 1'b1, 320};

        crt_keep  = 1'b0;
        pre_frame = '0;
        crt_frame = '0;
        rst       = 1'b0;
        #12;
        do_reset();
        idle(10);

        // Directed block vectors
        for (int v = 0; v < 4; v++) begin
            for (int r = 0; r < 8; r++) begin
                tick(1'b1, vecs[v].pre, vecs[v].crt);
                if (vecs[v].gaps && r < 7) tick(1'b0, vecs[v].pre, vecs[v].crt);
            end
            idle(LAT);
            check(vecs[v].name, sad_data, vecs[v].exp);
        end

        // Back-to-back blocks with no bubble
        for (int r = 0; r < 8; r++) tick(1'b1, 64'h0, 64'h0);
        for (int r = 0; r < 16; r++) tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        idle(LAT);
        check("back_to_back", sad_data, 16320);

        // Reset mid-block discards the partial block
        for (int r = 0; r < 4; r++) tick(1'b1, 64'h7777_7777_7777_7777, 64'h0);
        do_reset();
        for (int r = 0; r < 8; r++) tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        idle(LAT);
        check("abort_block", sad_data, 16320);

        // Single pixel differing by 200 in row i
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < 8; r++) begin
                p = {$urandom, $urandom};
                c = p;
                if (r == i) begin
                    p[8*i +: 8] = 8'd240;
                    c[8*i +: 8] = 8'd40;
                end
                tick(1'b1, p, c);
            end
            idle(LAT);
            check("pixel", sad_data, 200);
        end

        // Random rows, random gaps, occasional reset
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                tick($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom});
            end
        end
        idle(LAT + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
